// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one 32-bit UART transmitter
// Sequences grant, load strobe, start strobe and busy completion per word; outputs are registered.
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                i_clk,
    input  logic                _rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [31:0]         o_data,
    output logic                o_fetch,
    output logic                o_transmit,
    input  logic                i_busy,
    output logic [ID_W-1:0]     o_grant_id,
    output logic                o_active,
    output logic                o_timeout_err
);
    localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [31:0]        data_q, data_d;
    logic               fetch_q, fetch_d;
    logic               transmit_q, transmit_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic               active_q, active_d;
    logic               err_q, err_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    pick_id;
    logic [31:0]        pick_data;
    logic [N_REQ-1:0]   grant_onehot;
    logic [ID_W-1:0]    ptr_after;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        req_dbl  = {req, req} >> ptr_q;
        req_rot  = req_dbl[N_REQ-1:0];
        pick_sum = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            end
        end
        if (pick_sum >= (ID_W+1)'(N_REQ)) begin
            pick_sum = pick_sum - (ID_W+1)'(N_REQ);
        end
        pick_id = pick_sum[ID_W-1:0];
    end

    always_comb begin
        pick_data    = '0;
        grant_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_data = req_data[32*i +: 32];
            end
            grant_onehot[i] = (ID_W'(i) == grant_q);
        end
        ptr_after = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;
    end

    // Strobes are registered one state ahead, so o_data settles a full cycle before o_fetch.
    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        data_d     = data_q;
        fetch_d    = 1'b0;
        transmit_d = 1'b0;
        grant_d    = grant_q;
        active_d   = active_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d  = pick_id;
                    data_d   = pick_data;
                    active_d = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                fetch_d = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                transmit_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    active_d  = 1'b0;
                    ptr_d     = ptr_after;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i_busy) begin
                    ack_d     = grant_onehot;
                    active_d  = 1'b0;
                    ptr_d     = ptr_after;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state_q    <= S_IDLE;
            ack_q      <= '0;
            data_q     <= '0;
            fetch_q    <= 1'b0;
            transmit_q <= 1'b0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            fetch_q    <= fetch_d;
            transmit_q <= transmit_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ack           = ack_q;
    assign o_data        = data_q;
    assign o_fetch       = fetch_q;
    assign o_transmit    = transmit_q;
    assign o_grant_id    = grant_q;
    assign o_active      = active_q;
    assign o_timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
// Instance a: GAP_CYCLES=16, BUSY_TIMEOUT=8; instance b: GAP_CYCLES=0, BUSY_TIMEOUT=16.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   req_a = '0, req_b = '0;
    logic [31:0]  word_a [4];
    logic [31:0]  word_b [4];
    logic [127:0] rdata_a, rdata_b;
    logic [3:0]   ack_a, ack_b;
    logic [31:0]  data_a, data_b;
    logic         fetch_a, fetch_b, xmit_a, xmit_b, busy_a, busy_b;
    logic         active_a, active_b, err_a, err_b;
    logic [1:0]   gid_a, gid_b;

    assign rdata_a = {word_a[3], word_a[2], word_a[1], word_a[0]};
    assign rdata_b = {word_b[3], word_b[2], word_b[1], word_b[0]};

    uart_tx_scheduler #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(16), .BUSY_TIMEOUT(8)) dut_a (
        .i_clk(clk), ._rst(rst_n), .req(req_a), .req_data(rdata_a), .ack(ack_a),
        .o_data(data_a), .o_fetch(fetch_a), .o_transmit(xmit_a), .i_busy(busy_a),
        .o_grant_id(gid_a), .o_active(active_a), .o_timeout_err(err_a));

    uart_tx_scheduler #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)) dut_b (
        .i_clk(clk), ._rst(rst_n), .req(req_b), .req_data(rdata_b), .ack(ack_b),
        .o_data(data_b), .o_fetch(fetch_b), .o_transmit(xmit_b), .i_busy(busy_b),
        .o_grant_id(gid_b), .o_active(active_b), .o_timeout_err(err_b));

    // Transmitter models: busy rises x_dly cycles after the start strobe and lasts x_len cycles.
    bit mute [2] = '{1'b0, 1'b0};
    int x_dly [2] = '{3, 3};
    int x_len [2] = '{40, 40};
    int wait_a, run_a, wait_b, run_b;
    logic pend_a, pend_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_a <= 1'b0; pend_a <= 1'b0; wait_a <= 0; run_a <= 0;
        end else if (xmit_a && !mute[0]) begin
            pend_a <= 1'b1; wait_a <= x_dly[0]; run_a <= x_len[0];
        end else if (pend_a) begin
            if (wait_a > 1) wait_a <= wait_a - 1;
            else begin pend_a <= 1'b0; busy_a <= 1'b1; end
        end else if (busy_a) begin
            if (run_a > 1) run_a <= run_a - 1;
            else busy_a <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_b <= 1'b0; pend_b <= 1'b0; wait_b <= 0; run_b <= 0;
        end else if (xmit_b && !mute[1]) begin
            pend_b <= 1'b1; wait_b <= x_dly[1]; run_b <= x_len[1];
        end else if (pend_b) begin
            if (wait_b > 1) wait_b <= wait_b - 1;
            else begin pend_b <= 1'b0; busy_b <= 1'b1; end
        end else if (busy_b) begin
            if (run_b > 1) run_b <= run_b - 1;
            else busy_b <= 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;
    int m_ptr [2] = '{0, 0};
    int gap_of [2] = '{16, 0};
    logic [31:0] wq [4][$];

    logic [3:0]  s_ack, s_req;
    logic [31:0] s_data;
    logic [1:0]  s_gid;
    logic        s_fetch, s_xmit, s_busy, s_active, s_err;

    task automatic sample(input int u);
        if (u == 0) begin
            s_ack = ack_a; s_data = data_a; s_fetch = fetch_a; s_xmit = xmit_a; s_busy = busy_a;
            s_gid = gid_a; s_active = active_a; s_err = err_a; s_req = req_a;
        end else begin
            s_ack = ack_b; s_data = data_b; s_fetch = fetch_b; s_xmit = xmit_b; s_busy = busy_b;
            s_gid = gid_b; s_active = active_b; s_err = err_b; s_req = req_b;
        end
    endtask

    task automatic set_req(input int u, input int k, input logic v);
        if (u == 0) req_a[k] = v; else req_b[k] = v;
    endtask

    task automatic set_word(input int u, input int k, input logic [31:0] w);
        if (u == 0) word_a[k] = w; else word_b[k] = w;
    endtask

    function automatic logic [31:0] get_word(input int u, input int k);
        return (u == 0) ? word_a[k] : word_b[k];
    endfunction

    // Round-robin rule: first requesting index at or after the pointer, wrapping modulo 4.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic check_zero_outputs(input int u, input string tag);
        sample(u);
        checks++; if (s_ack !== 4'b0) begin failures++; $display("FAIL %s ack: got %b expected 0000", tag, s_ack); end
        checks++; if (s_fetch !== 1'b0 || s_xmit !== 1'b0) begin failures++; $display("FAIL %s strobes: got fetch=%b transmit=%b expected 0/0", tag, s_fetch, s_xmit); end
        checks++; if (s_data !== 32'h0) begin failures++; $display("FAIL %s o_data: got %h expected 00000000", tag, s_data); end
        checks++; if (s_gid !== 2'd0) begin failures++; $display("FAIL %s o_grant_id: got %0d expected 0", tag, s_gid); end
        checks++; if (s_active !== 1'b0 || s_err !== 1'b0) begin failures++; $display("FAIL %s active/err: got %b/%b expected 0/0", tag, s_active, s_err); end
    endtask

    // Drives requesters from a word queue, checks each grant, strobe and ack against the model.
    task automatic serve(input int u, input int rounds, input logic [3:0] mask, output int first_gid);
        int total, served, cyc, fetch_cyc, ack_cyc, fall_cyc, exp_gid;
        bit have_ack, pend_at_ack, prev_busy;
        logic [3:0] exp_ack;
        logic [3:0] cur;
        first_gid = -1; total = 0; served = 0; cyc = 0; fetch_cyc = -100;
        ack_cyc = -100; fall_cyc = -100; exp_gid = -1;
        have_ack = 1'b0; pend_at_ack = 1'b0; prev_busy = 1'b0;
        sample(u);
        cur = s_req;
        for (int k = 0; k < 4; k++) begin
            wq[k].delete();
            if (mask[k]) begin
                for (int r = 0; r < rounds; r++) begin
                    if (r == 0 && cur[k]) wq[k].push_back(get_word(u, k));
                    else wq[k].push_back($urandom);
                end
                total += rounds;
                set_word(u, k, wq[k][0]);
                set_req(u, k, 1'b1);
            end
        end
        while (served < total && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            sample(u);
            if (s_fetch) begin
                exp_gid = rr_pick(s_req, m_ptr[u]);
                checks++;
                if (exp_gid < 0 || s_gid !== 2'(exp_gid)) begin
                    failures++; $display("FAIL serve%0d grant: got %0d expected %0d", u, s_gid, exp_gid);
                    break;
                end
                checks++;
                if (s_data !== wq[exp_gid][0]) begin failures++; $display("FAIL serve%0d data: got %h expected %h", u, s_data, wq[exp_gid][0]); end
                checks++;
                if (s_xmit !== 1'b0 || s_active !== 1'b1) begin failures++; $display("FAIL serve%0d fetch cycle: got transmit=%b active=%b expected 0/1", u, s_xmit, s_active); end
                if (have_ack && pend_at_ack) begin
                    checks++;
                    if (cyc - ack_cyc != gap_of[u] + 2) begin failures++; $display("FAIL serve%0d ack-to-fetch: got %0d expected %0d", u, cyc - ack_cyc, gap_of[u] + 2); end
                end
                if (first_gid < 0) first_gid = exp_gid;
                fetch_cyc = cyc;
            end
            if (s_xmit) begin
                checks++;
                if (cyc != fetch_cyc + 1) begin failures++; $display("FAIL serve%0d transmit timing: got %0d expected %0d", u, cyc, fetch_cyc + 1); end
            end
            if (prev_busy && !s_busy) fall_cyc = cyc;
            prev_busy = s_busy;
            if (s_ack != 4'b0) begin
                checks++;
                if (exp_gid < 0) begin
                    failures++; $display("FAIL serve%0d ack without grant: got %b expected none", u, s_ack);
                    break;
                end
                exp_ack = 4'(1 << exp_gid);
                if (s_ack !== exp_ack) begin failures++; $display("FAIL serve%0d ack: got %b expected %b", u, s_ack, exp_ack); end
                checks++;
                if (cyc != fall_cyc + 1 || s_active !== 1'b0) begin failures++; $display("FAIL serve%0d ack timing: got cyc %0d active %b expected cyc %0d active 0", u, cyc, s_active, fall_cyc + 1); end
                void'(wq[exp_gid].pop_front());
                served++;
                m_ptr[u] = (exp_gid + 1) % 4;
                if (wq[exp_gid].size() > 0) set_word(u, exp_gid, wq[exp_gid][0]);
                else set_req(u, exp_gid, 1'b0);
                have_ack = 1'b1;
                ack_cyc = cyc;
                pend_at_ack = ((u == 0) ? req_a : req_b) != 4'b0;
                exp_gid = -1;
            end
        end
        checks++;
        if (served != total) begin failures++; $display("FAIL serve%0d completion: got %0d words expected %0d", u, served, total); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs(0, "reset_a");
        check_zero_outputs(1, "reset_b");
        rst_n = 1'b1;
        m_ptr[0] = 0; m_ptr[1] = 0;
    endtask

    task automatic test_single();
        int fetch_cyc = -1, xmit_cyc = -1, fall_cyc = -100, ack_cyc = -1, n_fetch = 0, n_xmit = 0, n_ack = 0;
        logic [31:0] fdata = '0;
        logic [1:0] fgid = '0;
        logic [3:0] got_ack = '0;
        logic act_at_ack = 1'b1, prev_busy = 1'b0;
        x_dly[0] = 3; x_len[0] = 40;
        @(negedge clk);
        for (int k = 0; k < 4; k++) word_a[k] = $urandom;
        word_a[1] = 32'hDEADBEEF;
        req_a = 4'b0010;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            sample(0);
            if (s_fetch) begin n_fetch++; fetch_cyc = cyc; fdata = s_data; fgid = s_gid; end
            if (s_xmit) begin n_xmit++; xmit_cyc = cyc; end
            if (prev_busy && !s_busy) fall_cyc = cyc;
            prev_busy = s_busy;
            if (s_ack != 4'b0) begin n_ack++; ack_cyc = cyc; got_ack = s_ack; act_at_ack = s_active; req_a = 4'b0; end
        end
        checks++; if (fetch_cyc != 2 || n_fetch != 1) begin failures++; $display("FAIL single fetch: got cycle %0d count %0d expected cycle 2 count 1", fetch_cyc, n_fetch); end
        checks++; if (fdata !== 32'hDEADBEEF || fgid !== 2'd1) begin failures++; $display("FAIL single data/grant: got %h/%0d expected deadbeef/1", fdata, fgid); end
        checks++; if (xmit_cyc != 3 || n_xmit != 1) begin failures++; $display("FAIL single transmit: got cycle %0d count %0d expected cycle 3 count 1", xmit_cyc, n_xmit); end
        checks++; if (got_ack !== 4'b0010 || n_ack != 1) begin failures++; $display("FAIL single ack: got %b x%0d expected 0010 x1", got_ack, n_ack); end
        checks++; if (ack_cyc != fall_cyc + 1 || act_at_ack !== 1'b0) begin failures++; $display("FAIL single ack timing: got %0d active %b expected %0d active 0", ack_cyc, act_at_ack, fall_cyc + 1); end
        m_ptr[0] = 2;
    endtask

    task automatic test_rotation(input int u);
        int fg;
        x_dly[u] = $urandom_range(1, 4);
        x_len[u] = $urandom_range(1, 20);
        serve(u, 2, 4'b1111, fg);
    endtask

    task automatic test_pointer_wrap();
        int fg;
        serve(0, 1, 4'b1000, fg);
        checks++; if (fg != 3) begin failures++; $display("FAIL wrap first: got %0d expected 3", fg); end
        serve(0, 1, 4'b1001, fg);
        checks++; if (fg != 0) begin failures++; $display("FAIL wrap next: got %0d expected 0", fg); end
    endtask

    task automatic test_timeout();
        int xmit_cyc = -100, err_cyc = -1, n_ack = 0, fg;
        logic act_at_err = 1'b1;
        logic [1:0] fgid = '0;
        mute[0] = 1'b1;
        @(negedge clk);
        word_a[2] = $urandom;
        req_a = 4'b0100;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            sample(0);
            if (s_fetch) fgid = s_gid;
            if (s_xmit) xmit_cyc = cyc;
            if (s_ack != 4'b0) n_ack++;
            if (s_err && err_cyc < 0) begin err_cyc = cyc; act_at_err = s_active; break; end
        end
        checks++; if (fgid !== 2'd2) begin failures++; $display("FAIL timeout grant: got %0d expected 2", fgid); end
        checks++; if (err_cyc != xmit_cyc + 8) begin failures++; $display("FAIL timeout err: got cycle %0d expected %0d", err_cyc, xmit_cyc + 8); end
        checks++; if (n_ack != 0 || act_at_err !== 1'b0) begin failures++; $display("FAIL timeout abort: got acks %0d active %b expected 0/0", n_ack, act_at_err); end
        mute[0] = 1'b0;
        m_ptr[0] = 3;
        x_dly[0] = 2; x_len[0] = 5;
        serve(0, 1, 4'b1100, fg);
        checks++; if (fg != 3) begin failures++; $display("FAIL timeout next: got %0d expected 3", fg); end
        sample(0);
        checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL timeout sticky: got %b expected 1", s_err); end
    endtask

    task automatic test_reset_abort();
        int fg;
        bit seen;
        x_dly[0] = 2; x_len[0] = 30;
        @(negedge clk);
        word_a[0] = $urandom; word_a[3] = $urandom;
        req_a = 4'b1001;
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk); sample(0);
            if (s_fetch) seen = 1'b1;
        end
        checks++; if (!seen || s_gid !== 2'(rr_pick(4'b1001, m_ptr[0]))) begin failures++; $display("FAIL abort grant: got %0d expected %0d", s_gid, rr_pick(4'b1001, m_ptr[0])); end
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk); sample(0);
            if (s_busy) seen = 1'b1;
        end
        repeat (2) @(negedge clk);
        sample(0);
        checks++; if (!seen || s_active !== 1'b1) begin failures++; $display("FAIL abort setup: got busy %b active %b expected 1/1", seen, s_active); end
        #2 rst_n = 1'b0;
        #1 check_zero_outputs(0, "abort_a");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr[0] = 0; m_ptr[1] = 0;
        serve(0, 1, 4'b1001, fg);
        checks++; if (fg != 0) begin failures++; $display("FAIL abort reserve: got %0d expected 0", fg); end
    endtask

    task automatic test_back_to_back();
        int fg;
        x_dly[1] = 1; x_len[1] = 4;
        serve(1, 4, 4'b0001, fg);
        checks++; if (fg != 0) begin failures++; $display("FAIL b2b grant: got %0d expected 0", fg); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin word_a[k] = '0; word_b[k] = '0; end
        test_reset();
        test_single();
        test_rotation(0);
        test_pointer_wrap();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        test_rotation(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 32-bit-word UART transmitter between N_REQ independent requesters (capture channels, status reporter, etc.).
- Round-robin arbitration; sequences the transmitter's load (fetch), start (transmit) and completion (busy) handshake per word.
- Returns a one-cycle acknowledge to the winning requester when its word has fully left the line.
- Sits between the capture/packetising logic and the UART transmitter.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant index; must be >= clog2(N_REQ)
GAP_CYCLES, 16, idle i_clk cycles enforced after busy falls before the next fetch (0 allowed)
BUSY_TIMEOUT, 1024, max i_clk cycles waiting for busy to rise after transmit pulse

Ports:
i_clk  input  1  system clock
_rst  input  1  asynchronous active-low reset
req  input  N_REQ  level request per requester; held until its ack
req_data  input  32*N_REQ  word per requester; requester k at bits [32k+31:32k]; must be stable while req[k] high
ack  output  N_REQ  one-cycle pulse to requester whose word completed
o_data  output  32  word driven to transmitter parallel load
o_fetch  output  1  one-cycle load strobe to transmitter
o_transmit  output  1  one-cycle start strobe to transmitter
i_busy  input  1  transmitter busy status
o_grant_id  output  ID_W  index of current/last granted requester
o_active  output  1  high from grant until ack (or abort)
o_timeout_err  output  1  sticky: transmitter failed to assert busy

Behaviour:
- Reset (async, _rst low): state IDLE, ack=0, o_fetch=0, o_transmit=0, o_data=0, o_grant_id=0, o_active=0, o_timeout_err=0, round-robin pointer=0, gap counter=0. Reset mid-word aborts silently: no ack issued; requester keeps req high and is served after reset.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req bit set, pick first set bit searching from pointer upward, wrapping modulo N_REQ; latch index into o_grant_id, latch req_data slice into o_data, o_active=1, -> LOAD. No req: stay.
- LOAD: o_fetch=1 for exactly this cycle; o_data stable one cycle before and during strobe. -> START.
- START: o_transmit=1 for exactly this cycle; clear timeout counter. -> WAIT_BUSY. fetch and transmit never asserted in same cycle.
- WAIT_BUSY: i_busy=1 -> WAIT_DONE. Counter reaches BUSY_TIMEOUT-1 with i_busy=0: set o_timeout_err, no ack, o_active=0, pointer advances past grant, -> GAP (word dropped; requester retries later by holding req).
- WAIT_DONE: on i_busy=0: ack[o_grant_id]=1 for one cycle, o_active=0, pointer = grant+1 mod N_REQ, -> GAP (or IDLE directly if GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles, then -> IDLE. Requests ignored during GAP.
- Latency: req rising in IDLE -> o_fetch in 2nd cycle, o_transmit in 3rd cycle.
- Requester dropping req after grant: word still sent, ack still pulsed (harmless).
- All requests simultaneous: each served exactly once per N_REQ words in rotation order; no starvation.
- o_timeout_err cleared only by reset.
- o_data, o_grant_id hold their values outside LOAD.
- i_busy treated as synchronous to i_clk (transmitter on same clock).

Test Plan:
- Single request: req=4'b0010, req_data[63:32]=32'hDEADBEEF, model busy high 3 cycles after transmit for 40 cycles -> o_data=DEADBEEF at o_fetch, one o_transmit pulse, ack=4'b0010 one cycle after busy falls, o_active low.
- All four req held high, distinct words -> transmitted order 0,1,2,3,0; each ack once per round; consecutive fetches separated by >= GAP_CYCLES cycles after busy fall.
- Pointer wrap: serve requester 3, then req=4'b1001 -> requester 0 granted next, not 3.
- Busy never asserts, BUSY_TIMEOUT=8 -> o_timeout_err rises 8 cycles after transmit, no ack, scheduler returns to IDLE and serves next requester.
- _rst low during WAIT_DONE -> all outputs zero immediately (async), no ack; after release held req re-served from pointer 0.
- GAP_CYCLES=0, back-to-back requests from one requester -> next o_fetch 2 cycles after ack, no fetch/transmit overlap.
